// File: rtl/fetch_pkg.sv
// Shared types and helpers for the halfword fetch queue.
// Optional stall counter in fetch_queue is enabled by FETCH_STALL_CNT_EN.
package fetch_pkg;

  localparam int unsigned HW_W = 16;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FULL,
    ST_FLUSH
  } fetch_state_t;

  // Bit 15 set marks the first halfword of a 32-bit instruction.
  function automatic logic is_long(input logic [HW_W-1:0] hw);
    return hw[HW_W-1];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Halfword queue: single push, pop of one or two entries, synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic [HW_W-1:0] i_data,
  input  logic            i_pop1,
  input  logic            i_pop2,
  output logic [HW_W-1:0] o_head0,
  output logic [HW_W-1:0] o_head1,
  output logic [CW-1:0]   o_count
);

  logic [HW_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_pop_cnt;
  logic [AW-1:0]   w_rd1;

  assign w_pop_cnt = i_pop2 ? CW'(2) : {{(CW-1){1'b0}}, i_pop1};
  assign w_rd1     = r_rd + AW'(1);
  assign o_head0   = r_mem[r_rd];
  assign o_head1   = r_mem[w_rd1];
  assign o_count   = r_count;

  always_ff @(posedge clock) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wr <= r_wr + AW'(1);
      end
      r_rd    <= r_rd + w_pop_cnt[AW-1:0];
      r_count <= r_count + CW'(i_push) - w_pop_cnt;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: requests halfwords, assembles 16/32-bit insns.
// Define FETCH_STALL_CNT_EN to add the stall_cnt output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 20,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     OFS_W    = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [HW_W-1:0]  imem_data,
  input  logic             redirect_valid,
  input  logic             redirect_abs,
  input  logic [PC_W-1:0]  redirect_target,
  input  logic [OFS_W-1:0] redirect_offset,
  output logic             insn_valid,
  input  logic             insn_ready,
  output logic [31:0]      insn_data,
  output logic             insn_long,
  output logic [PC_W-1:0]  insn_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  logic            r_live;
  logic            r_inflight;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_insn_pc;

  logic [HW_W-1:0] w_head0;
  logic [HW_W-1:0] w_head1;
  logic [CW-1:0]   w_count;
  logic            w_head_long;
  logic            w_valid;
  logic            w_pop;
  logic            w_pop1;
  logic            w_pop2;
  logic            w_push;
  logic            w_req;
  logic [PC_W-1:0] w_ofs_ext;
  logic [PC_W-1:0] w_target;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_used_nxt;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (imem_data),
    .i_pop1  (w_pop1),
    .i_pop2  (w_pop2),
    .o_head0 (w_head0),
    .o_head1 (w_head1),
    .o_count (w_count)
  );

  assign w_head_long = is_long(w_head0);
  assign w_valid     = (w_count != '0) && (!w_head_long || (w_count >= CW'(2)));
  assign w_pop       = w_valid && insn_ready && !redirect_valid;
  assign w_pop1      = w_pop && !w_head_long;
  assign w_pop2      = w_pop && w_head_long;
  assign w_push      = r_inflight && (r_state != ST_FLUSH) && !redirect_valid;
  assign w_req       = r_live && !redirect_valid && (r_state != ST_FULL);

  assign w_ofs_ext = {{(PC_W-OFS_W){redirect_offset[OFS_W-1]}}, redirect_offset};
  assign w_target  = redirect_abs ? redirect_target : (r_insn_pc + w_ofs_ext);

  // Occupancy plus outstanding request as it will stand after this edge.
  assign w_count_nxt = redirect_valid ? '0 :
                       (w_count + CW'(w_push) - (w_pop2 ? CW'(2) : CW'(w_pop1)));
  assign w_used_nxt  = w_count_nxt + CW'(w_req);

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign insn_valid = w_valid;
  assign insn_long  = w_valid && w_head_long;
  assign insn_data  = w_valid ? {w_head0, (w_head_long ? w_head1 : '0)} : '0;
  assign insn_pc    = r_insn_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_live     <= 1'b0;
      r_inflight <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_insn_pc  <= RESET_PC;
    end else begin
      r_live     <= 1'b1;
      r_inflight <= w_req;
      if (redirect_valid) begin
        r_state    <= ST_FLUSH;
        r_fetch_pc <= w_target;
        r_insn_pc  <= w_target;
      end else begin
        if (w_req) begin
          r_fetch_pc <= r_fetch_pc + PC_W'(1);
        end
        if (w_pop) begin
          r_insn_pc <= r_insn_pc + (w_pop2 ? PC_W'(2) : PC_W'(1));
        end
        case (r_state)
          ST_FLUSH: r_state <= ST_RUN;
          default:  r_state <= (w_used_nxt == CW'(DEPTH)) ? ST_FULL : ST_RUN;
        endcase
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (insn_ready && !w_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
